core_frame_rx: RTL and testbench

//  Per-core receiver downstream of the scheduler. Accepts one 16-bit word per cycle on the scheduler-to-core bus.

---
 rtl/core_frame_rx.sv | 218 +++++++++++++++++++++
 tb/tb_core_frame_rx.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : core_frame_rx
// Brief    : Per-core frame receiver. Parses a header frame plus instruction
//            frames from the scheduler bus, loads R0 lanes and instruction
//            memory, then pulses start and holds off until core_done.
// Revision : 1.0
// ============================================================================
module core_frame_rx #(
    parameter int CORE_ID     = 0,
    parameter int INSTR_SIZE  = 16,
    parameter int FRAME_WORDS = 16,
    parameter int R0_DEPTH    = 8,
    parameter int IMEM_DEPTH  = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [INSTR_SIZE-1:0]         bus_data,
    input  logic                          bus_valid,
    input  logic                          bus_sof,
    output logic                          bus_ready,
    output logic                          core_ready,
    output logic                          core_reading,
    input  logic                          core_done,
    output logic                          imem_we,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    output logic [INSTR_SIZE-1:0]         imem_wdata,
    output logic                          r0_we,
    output logic [$clog2(R0_DEPTH)-1:0]   r0_idx,
    output logic [INSTR_SIZE-1:0]         r0_wdata,
    output logic                          start,
    output logic [1:0]                    fence_out
);

    localparam int AW      = $clog2(IMEM_DEPTH);
    localparam int CW      = $clog2(FRAME_WORDS);
    localparam int RW      = $clog2(R0_DEPTH);
    localparam int NW      = AW + 1;
    localparam int R0_BASE = FRAME_WORDS - R0_DEPTH;

    localparam logic [CW-1:0] HDR_MASK  = CW'(1);
    localparam logic [CW-1:0] HDR_LANES = CW'(2);
    localparam logic [CW-1:0] HDR_R0    = CW'(R0_BASE);
    localparam logic [CW-1:0] HDR_LAST  = CW'(FRAME_WORDS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_INSTR = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         hdr_cnt_q, hdr_cnt_d;
    logic [AW-1:0]         instr_cnt_q, instr_cnt_d;
    logic [1:0]            if_num_q, if_num_d;
    logic [1:0]            fence_q, fence_d;
    logic                  selected_q, selected_d;
    logic [R0_DEPTH-1:0]   lane_mask_q, lane_mask_d;

    logic                  bus_ready_q, bus_ready_d;
    logic                  core_ready_q, core_ready_d;
    logic                  core_reading_q, core_reading_d;
    logic                  imem_we_q, imem_we_d;
    logic [AW-1:0]         imem_addr_q, imem_addr_d;
    logic [INSTR_SIZE-1:0] imem_wdata_q, imem_wdata_d;
    logic                  r0_we_q, r0_we_d;
    logic [RW-1:0]         r0_idx_q, r0_idx_d;
    logic [INSTR_SIZE-1:0] r0_wdata_q, r0_wdata_d;
    logic                  start_q, start_d;
    logic [1:0]            fence_out_q, fence_out_d;

    logic                  w_accept;
    logic                  w_hdr_last;
    logic                  w_instr_last;
    logic [NW-1:0]         w_instr_total;
    logic [RW-1:0]         w_lane;

    assign w_accept      = bus_valid & bus_ready_q;
    assign w_hdr_last    = (hdr_cnt_q == HDR_LAST);
    assign w_instr_total = NW'(if_num_q) * NW'(FRAME_WORDS);
    assign w_instr_last  = ({1'b0, instr_cnt_q} == (w_instr_total - NW'(1)));
    assign w_lane        = RW'(hdr_cnt_q - HDR_R0);

    // State register and all registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            hdr_cnt_q      <= '0;
            instr_cnt_q    <= '0;
            if_num_q       <= '0;
            fence_q        <= '0;
            selected_q     <= 1'b0;
            lane_mask_q    <= '0;
            bus_ready_q    <= 1'b1;
            core_ready_q   <= 1'b1;
            core_reading_q <= 1'b0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
            r0_we_q        <= 1'b0;
            r0_idx_q       <= '0;
            r0_wdata_q     <= '0;
            start_q        <= 1'b0;
            fence_out_q    <= '0;
        end else begin
            state_q        <= state_d;
            hdr_cnt_q      <= hdr_cnt_d;
            instr_cnt_q    <= instr_cnt_d;
            if_num_q       <= if_num_d;
            fence_q        <= fence_d;
            selected_q     <= selected_d;
            lane_mask_q    <= lane_mask_d;
            bus_ready_q    <= bus_ready_d;
            core_ready_q   <= core_ready_d;
            core_reading_q <= core_reading_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            r0_we_q        <= r0_we_d;
            r0_idx_q       <= r0_idx_d;
            r0_wdata_q     <= r0_wdata_d;
            start_q        <= start_d;
            fence_out_q    <= fence_out_d;
        end
    end

    // Next-state logic; a start-of-frame word always restarts header parsing
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept && bus_sof) state_d = S_HDR;
            end
            S_HDR: begin
                if (w_accept) begin
                    if (bus_sof)         state_d = S_HDR;
                    else if (w_hdr_last) state_d = (if_num_q != 2'd0) ? S_INSTR : S_RUN;
                end
            end
            S_INSTR: begin
                if (w_accept) begin
                    if (bus_sof)           state_d = S_HDR;
                    else if (w_instr_last) state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (selected_q)                state_d = S_WAIT;
                else if (w_accept && bus_sof)  state_d = S_HDR;
                else                           state_d = S_IDLE;
            end
            S_WAIT: begin
                if (core_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output logic
    always_comb begin
        hdr_cnt_d    = hdr_cnt_q;
        instr_cnt_d  = instr_cnt_q;
        if_num_d     = if_num_q;
        fence_d      = fence_q;
        selected_d   = selected_q;
        lane_mask_d  = lane_mask_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        r0_we_d      = 1'b0;
        r0_idx_d     = r0_idx_q;
        r0_wdata_d   = r0_wdata_q;

        start_d        = (state_q == S_RUN) && selected_q;
        fence_out_d    = start_d ? fence_q : fence_out_q;
        bus_ready_d    = !((state_d == S_WAIT) || ((state_d == S_RUN) && selected_q));
        core_ready_d   = (state_d == S_IDLE);
        core_reading_d = (state_d == S_HDR) || (state_d == S_INSTR);

        if (w_accept && bus_sof) begin
            hdr_cnt_d   = CW'(1);
            instr_cnt_d = '0;
            if_num_d    = bus_data[1:0];
            fence_d     = bus_data[3:2];
            selected_d  = 1'b0;
            lane_mask_d = '0;
        end else if (w_accept && (state_q == S_HDR)) begin
            hdr_cnt_d = hdr_cnt_q + CW'(1);
            if (hdr_cnt_q == HDR_MASK)  selected_d  = bus_data[CORE_ID];
            if (hdr_cnt_q == HDR_LANES) lane_mask_d = bus_data[R0_DEPTH-1:0];
            if ((hdr_cnt_q >= HDR_R0) && selected_q && lane_mask_q[w_lane]) begin
                r0_we_d    = 1'b1;
                r0_idx_d   = w_lane;
                r0_wdata_d = bus_data;
            end
        end else if (w_accept && (state_q == S_INSTR)) begin
            instr_cnt_d = instr_cnt_q + AW'(1);
            if (selected_q) begin
                imem_we_d    = 1'b1;
                imem_addr_d  = instr_cnt_q;
                imem_wdata_d = bus_data;
            end
        end
    end

    assign bus_ready    = bus_ready_q;
    assign core_ready   = core_ready_q;
    assign core_reading = core_reading_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign r0_we        = r0_we_q;
    assign r0_idx       = r0_idx_q;
    assign r0_wdata     = r0_wdata_q;
    assign start        = start_q;
    assign fence_out    = fence_out_q;

endmodule
`default_nettype wire

// File: tb/tb_core_frame_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_core_frame_rx
// Brief    : Randomized self-checking bench for core_frame_rx (cores 0 and 4).
// Revision : 1.0
// ============================================================================
module tb_core_frame_rx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] bus_data;
    logic        bus_valid, bus_sof, tgt;
    logic        core_done_a, core_done_b;
    logic        valid_a, valid_b, cur_ready;

    logic        a_bus_ready, a_core_ready, a_core_reading, a_imem_we, a_r0_we, a_start;
    logic [5:0]  a_imem_addr;
    logic [15:0] a_imem_wdata, a_r0_wdata;
    logic [2:0]  a_r0_idx;
    logic [1:0]  a_fence;
    logic        b_bus_ready, b_core_ready, b_core_reading, b_imem_we, b_r0_we, b_start;
    logic [5:0]  b_imem_addr;
    logic [15:0] b_imem_wdata, b_r0_wdata;
    logic [2:0]  b_r0_idx;
    logic [1:0]  b_fence;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int hdr_acc [16];

    logic [15:0] hdr [16];
    logic [15:0] instr [48];
    logic [18:0] exp_r0 [$];
    logic [21:0] exp_im [$];
    bit          exp_sel;

    logic [18:0] obs_r0_a [$];
    int          obs_r0_cyc_a [$];
    logic [21:0] obs_im_a [$];
    logic [18:0] obs_r0_b [$];
    logic [21:0] obs_im_b [$];
    int start_cnt_a = 0;
    int start_cnt_b = 0;
    int rdy_low_b   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign valid_a   = bus_valid & ~tgt;
    assign valid_b   = bus_valid & tgt;
    assign cur_ready = tgt ? b_bus_ready : a_bus_ready;

    core_frame_rx #(.CORE_ID(0)) dut_a (
        .clk(clk), .reset(reset_n), .bus_data(bus_data), .bus_valid(valid_a), .bus_sof(bus_sof),
        .bus_ready(a_bus_ready), .core_ready(a_core_ready), .core_reading(a_core_reading),
        .core_done(core_done_a), .imem_we(a_imem_we), .imem_addr(a_imem_addr),
        .imem_wdata(a_imem_wdata), .r0_we(a_r0_we), .r0_idx(a_r0_idx), .r0_wdata(a_r0_wdata),
        .start(a_start), .fence_out(a_fence)
    );

    core_frame_rx #(.CORE_ID(4)) dut_b (
        .clk(clk), .reset(reset_n), .bus_data(bus_data), .bus_valid(valid_b), .bus_sof(bus_sof),
        .bus_ready(b_bus_ready), .core_ready(b_core_ready), .core_reading(b_core_reading),
        .core_done(core_done_b), .imem_we(b_imem_we), .imem_addr(b_imem_addr),
        .imem_wdata(b_imem_wdata), .r0_we(b_r0_we), .r0_idx(b_r0_idx), .r0_wdata(b_r0_wdata),
        .start(b_start), .fence_out(b_fence)
    );

    // Observed write streams, sampled mid-cycle
    always @(negedge clk) begin
        if (a_r0_we) begin
            obs_r0_a.push_back({a_r0_idx, a_r0_wdata});
            obs_r0_cyc_a.push_back(cyc);
        end
        if (a_imem_we) obs_im_a.push_back({a_imem_addr, a_imem_wdata});
        if (a_start)   start_cnt_a <= start_cnt_a + 1;
        if (b_r0_we)   obs_r0_b.push_back({b_r0_idx, b_r0_wdata});
        if (b_imem_we) obs_im_b.push_back({b_imem_addr, b_imem_wdata});
        if (b_start)   start_cnt_b <= start_cnt_b + 1;
        if (!b_bus_ready) rdy_low_b <= rdy_low_b + 1;
    end

    task automatic send_word(input logic [15:0] d, input logic sof, input bit gap);
        int guard;
        guard = 0;
        if (gap) @(negedge clk);
        @(negedge clk);
        bus_data  = d;
        bus_sof   = sof;
        bus_valid = 1'b1;
        while (!cur_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!cur_ready) begin
            n_vec++; n_err++;
            $display("FAIL ready_timeout: bus_ready=0 required=1");
        end
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        bus_valid = 1'b0;
        bus_sof   = 1'b0;
    endtask

    task automatic send_program(input bit gap, input int n_instr);
        for (int i = 0; i < 16; i++) begin
            send_word(hdr[i], (i == 0), gap);
            hdr_acc[i] = acc_cyc;
        end
        for (int k = 0; k < n_instr; k++) send_word(instr[k], 1'b0, gap);
    endtask

    task automatic make_program(input logic [1:0] ifn, input logic [1:0] fence,
                                input logic [15:0] mask, input logic [15:0] lmask, input bit seq);
        hdr[0] = {12'h000, fence, ifn};
        hdr[1] = mask;
        hdr[2] = lmask;
        for (int i = 3; i < 8; i++)  hdr[i] = 16'($urandom);
        for (int i = 8; i < 16; i++) hdr[i] = seq ? 16'(i - 7) : 16'($urandom);
        for (int k = 0; k < 48; k++) instr[k] = 16'($urandom);
    endtask

    // Reference model: what a core with the given id must write for the current program
    task automatic expect_for(input int core_id);
        int ifn;
        exp_sel = hdr[1][core_id];
        ifn     = int'(hdr[0][1:0]);
        for (int n = 0; n < 8; n++)
            if (exp_sel && hdr[2][n]) exp_r0.push_back({3'(n), hdr[8 + n]});
        for (int k = 0; k < ifn * 16; k++)
            if (exp_sel) exp_im.push_back({6'(k), instr[k]});
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({a_bus_ready, a_core_ready, a_core_reading, a_imem_we, a_r0_we, a_start, a_fence} !== 8'b1100_0000) begin
            n_err++;
            $display("FAIL reset_a: got %b expected 11000000",
                     {a_bus_ready, a_core_ready, a_core_reading, a_imem_we, a_r0_we, a_start, a_fence});
        end
        n_vec++;
        if ({a_imem_addr, a_imem_wdata, a_r0_idx, a_r0_wdata} !== 41'd0) begin
            n_err++; $display("FAIL reset_a_data: got nonzero expected 0");
        end
        n_vec++;
        if ({b_bus_ready, b_core_ready, b_core_reading, b_start} !== 4'b1100) begin
            n_err++; $display("FAIL reset_b: got %b expected 1100", {b_bus_ready, b_core_ready, b_core_reading, b_start});
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_load();
        int br, bi, bs;
        make_program(2'd2, 2'd0, 16'h0F0F, 16'h00FF, 1'b1);
        exp_r0.delete(); exp_im.delete(); expect_for(0);
        br = obs_r0_a.size(); bi = obs_im_a.size(); bs = start_cnt_a;
        @(negedge clk) core_done_a = 1'b1;
        @(negedge clk) core_done_a = 1'b0;
        send_program(1'b0, 32);
        repeat (4) @(negedge clk);
        #1;
        n_vec++;
        if (obs_r0_a.size() - br !== 8) begin
            n_err++; $display("FAIL load_r0_count: got %0d expected 8", obs_r0_a.size() - br);
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_vec++;
                if (obs_r0_a[br + i] !== {3'(i), 16'(i + 1)}) begin
                    n_err++; $display("FAIL load_r0[%0d]: got %h expected %h", i, obs_r0_a[br + i], {3'(i), 16'(i + 1)});
                end
                n_vec++;
                if (obs_r0_cyc_a[br + i] !== hdr_acc[8 + i]) begin
                    n_err++; $display("FAIL load_r0_latency[%0d]: got cycle %0d expected %0d", i, obs_r0_cyc_a[br + i], hdr_acc[8 + i]);
                end
            end
        end
        n_vec++;
        if (obs_im_a.size() - bi !== 32) begin
            n_err++; $display("FAIL load_im_count: got %0d expected 32", obs_im_a.size() - bi);
        end else begin
            for (int i = 0; i < 32; i++) begin
                n_vec++;
                if (obs_im_a[bi + i] !== exp_im[i]) begin
                    n_err++; $display("FAIL load_im[%0d]: got %h expected %h", i, obs_im_a[bi + i], exp_im[i]);
                end
            end
        end
        n_vec++;
        if (start_cnt_a - bs !== 1) begin
            n_err++; $display("FAIL load_start: got %0d pulses expected 1", start_cnt_a - bs);
        end
        n_vec++;
        if ({a_core_ready, a_bus_ready} !== 2'b00) begin
            n_err++; $display("FAIL load_holdoff: got %b expected 00", {a_core_ready, a_bus_ready});
        end
        @(negedge clk) core_done_a = 1'b1;
        @(negedge clk) core_done_a = 1'b0;
        n_vec++;
        if ({a_core_ready, a_bus_ready} !== 2'b11) begin
            n_err++; $display("FAIL load_done_idle: got %b expected 11", {a_core_ready, a_bus_ready});
        end
    endtask

    task automatic test_not_selected();
        int br, bi, bs, bl, ba;
        tgt = 1'b1;
        make_program(2'd2, 2'd0, 16'h0F0F, 16'h00FF, 1'b1);
        br = obs_r0_b.size(); bi = obs_im_b.size(); bs = start_cnt_b; bl = rdy_low_b; ba = obs_im_a.size();
        send_program(1'b0, 32);
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if ((obs_r0_b.size() - br) + (obs_im_b.size() - bi) + (start_cnt_b - bs) !== 0) begin
            n_err++; $display("FAIL unsel_strobes: got %0d strobes expected 0",
                              (obs_r0_b.size() - br) + (obs_im_b.size() - bi) + (start_cnt_b - bs));
        end
        n_vec++;
        if (rdy_low_b - bl !== 0) begin
            n_err++; $display("FAIL unsel_bus_ready: got %0d low cycles expected 0", rdy_low_b - bl);
        end
        n_vec++;
        if ({b_core_ready, b_core_reading, b_fence} !== 4'b1000) begin
            n_err++; $display("FAIL unsel_idle: got %b expected 1000", {b_core_ready, b_core_reading, b_fence});
        end
        n_vec++;
        if (obs_im_a.size() - ba !== 0) begin
            n_err++; $display("FAIL unsel_other_core: got %0d writes expected 0", obs_im_a.size() - ba);
        end
        tgt = 1'b0;
    endtask

    task automatic test_core_id_select();
        int br, bi, bs;
        tgt = 1'b1;
        make_program(2'd1, 2'd3, 16'h0010, 16'($urandom), 1'b0);
        exp_r0.delete(); exp_im.delete(); expect_for(4);
        br = obs_r0_b.size(); bi = obs_im_b.size(); bs = start_cnt_b;
        send_program(1'b0, 16);
        repeat (4) @(negedge clk);
        #1;
        n_vec++;
        if ((obs_r0_b.size() - br !== exp_r0.size()) || (obs_im_b.size() - bi !== exp_im.size())) begin
            n_err++; $display("FAIL sel4_counts: got r0=%0d im=%0d expected r0=%0d im=%0d",
                              obs_r0_b.size() - br, obs_im_b.size() - bi, exp_r0.size(), exp_im.size());
        end else begin
            for (int i = 0; i < exp_r0.size(); i++) begin
                n_vec++;
                if (obs_r0_b[br + i] !== exp_r0[i]) begin
                    n_err++; $display("FAIL sel4_r0[%0d]: got %h expected %h", i, obs_r0_b[br + i], exp_r0[i]);
                end
            end
            for (int i = 0; i < exp_im.size(); i++) begin
                n_vec++;
                if (obs_im_b[bi + i] !== exp_im[i]) begin
                    n_err++; $display("FAIL sel4_im[%0d]: got %h expected %h", i, obs_im_b[bi + i], exp_im[i]);
                end
            end
        end
        n_vec++;
        if ({start_cnt_b - bs, b_fence} !== {32'd1, 2'd3}) begin
            n_err++; $display("FAIL sel4_start_fence: got start=%0d fence=%0d expected 1/3", start_cnt_b - bs, b_fence);
        end
        @(negedge clk) core_done_b = 1'b1;
        @(negedge clk) core_done_b = 1'b0;
        n_vec++;
        if (b_core_ready !== 1'b1) begin
            n_err++; $display("FAIL sel4_done: got core_ready=%b expected 1", b_core_ready);
        end
        tgt = 1'b0;
    endtask

    task automatic test_lane_mask();
        int br;
        make_program(2'd2, 2'd0, 16'h0F0F, 16'h0005, 1'b0);
        exp_r0.delete(); exp_im.delete(); expect_for(0);
        br = obs_r0_a.size();
        send_program(1'b0, 32);
        repeat (4) @(negedge clk);
        #1;
        n_vec++;
        if (obs_r0_a.size() - br !== 2) begin
            n_err++; $display("FAIL lanes_count: got %0d expected 2", obs_r0_a.size() - br);
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (obs_r0_a[br + i] !== exp_r0[i]) begin
                    n_err++; $display("FAIL lanes[%0d]: got %h expected %h", i, obs_r0_a[br + i], exp_r0[i]);
                end
            end
        end
        @(negedge clk) core_done_a = 1'b1;
        @(negedge clk) core_done_a = 1'b0;
    endtask

    // if_num = 0, with core_done already high when start fires
    task automatic test_no_instr();
        int bs;
        make_program(2'd0, 2'd1, 16'h0F0F, 16'h00FF, 1'b0);
        bs = start_cnt_a;
        core_done_a = 1'b1;
        send_program(1'b0, 0);
        @(negedge clk);
        n_vec++;
        if (a_start !== 1'b0) begin
            n_err++; $display("FAIL noinstr_early: got start=%b expected 0", a_start);
        end
        @(negedge clk);
        n_vec++;
        if ({a_start, a_core_ready, a_fence} !== 4'b1001) begin
            n_err++; $display("FAIL noinstr_start: got %b expected 1001", {a_start, a_core_ready, a_fence});
        end
        @(negedge clk);
        core_done_a = 1'b0;
        n_vec++;
        if ({a_start, a_core_ready, a_bus_ready} !== 3'b011) begin
            n_err++; $display("FAIL noinstr_done_same_cycle: got %b expected 011", {a_start, a_core_ready, a_bus_ready});
        end
        #1;
        n_vec++;
        if (start_cnt_a - bs !== 1) begin
            n_err++; $display("FAIL noinstr_pulses: got %0d expected 1", start_cnt_a - bs);
        end
    endtask

    task automatic test_abort();
        int br, bi, bs;
        make_program(2'd2, 2'd0, 16'h0F0F, 16'($urandom), 1'b0);
        exp_r0.delete(); exp_im.delete(); expect_for(0);
        while (exp_im.size() > 10) void'(exp_im.pop_back());
        br = obs_r0_a.size(); bi = obs_im_a.size(); bs = start_cnt_a;
        send_program(1'b0, 10);
        repeat (3) @(negedge clk);
        n_vec++;
        if ({start_cnt_a - bs, a_core_reading} !== {32'd0, 1'b1}) begin
            n_err++; $display("FAIL abort_stall: got start=%0d reading=%b expected 0/1", start_cnt_a - bs, a_core_reading);
        end
        make_program(2'd1, 2'd2, 16'h0F0F, 16'($urandom), 1'b0);
        expect_for(0);
        send_program(1'b0, 16);
        repeat (4) @(negedge clk);
        #1;
        n_vec++;
        if ((obs_r0_a.size() - br !== exp_r0.size()) || (obs_im_a.size() - bi !== exp_im.size())) begin
            n_err++; $display("FAIL abort_counts: got r0=%0d im=%0d expected r0=%0d im=%0d",
                              obs_r0_a.size() - br, obs_im_a.size() - bi, exp_r0.size(), exp_im.size());
        end else begin
            for (int i = 0; i < exp_r0.size(); i++) begin
                n_vec++;
                if (obs_r0_a[br + i] !== exp_r0[i]) begin
                    n_err++; $display("FAIL abort_r0[%0d]: got %h expected %h", i, obs_r0_a[br + i], exp_r0[i]);
                end
            end
            for (int i = 0; i < exp_im.size(); i++) begin
                n_vec++;
                if (obs_im_a[bi + i] !== exp_im[i]) begin
                    n_err++; $display("FAIL abort_im[%0d]: got %h expected %h", i, obs_im_a[bi + i], exp_im[i]);
                end
            end
        end
        n_vec++;
        if ({start_cnt_a - bs, a_fence} !== {32'd1, 2'd2}) begin
            n_err++; $display("FAIL abort_start: got start=%0d fence=%0d expected 1/2", start_cnt_a - bs, a_fence);
        end
        @(negedge clk) core_done_a = 1'b1;
        @(negedge clk) core_done_a = 1'b0;
    endtask

    task automatic test_valid_toggle();
        int br, bi, bs;
        make_program(2'd2, 2'd0, 16'h0F0F, 16'h00FF, 1'b1);
        exp_r0.delete(); exp_im.delete(); expect_for(0);
        br = obs_r0_a.size(); bi = obs_im_a.size(); bs = start_cnt_a;
        send_program(1'b1, 32);
        repeat (4) @(negedge clk);
        #1;
        n_vec++;
        if ((obs_r0_a.size() - br !== 8) || (obs_im_a.size() - bi !== 32) || (start_cnt_a - bs !== 1)) begin
            n_err++; $display("FAIL toggle_counts: got r0=%0d im=%0d start=%0d expected 8/32/1",
                              obs_r0_a.size() - br, obs_im_a.size() - bi, start_cnt_a - bs);
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_vec++;
                if (obs_r0_a[br + i] !== exp_r0[i]) begin
                    n_err++; $display("FAIL toggle_r0[%0d]: got %h expected %h", i, obs_r0_a[br + i], exp_r0[i]);
                end
            end
            for (int i = 0; i < 32; i++) begin
                n_vec++;
                if (obs_im_a[bi + i] !== exp_im[i]) begin
                    n_err++; $display("FAIL toggle_im[%0d]: got %h expected %h", i, obs_im_a[bi + i], exp_im[i]);
                end
            end
        end
        @(negedge clk) core_done_a = 1'b1;
        @(negedge clk) core_done_a = 1'b0;
        // Reset asynchronously while an instruction write strobe is active
        make_program(2'd2, 2'd0, 16'h0F0F, 16'h00FF, 1'b0);
        send_program(1'b0, 5);
        n_vec++;
        if (a_imem_we !== 1'b1) begin
            n_err++; $display("FAIL midinstr_we: got %b expected 1", a_imem_we);
        end
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if ({a_core_ready, a_bus_ready, a_imem_we, a_core_reading, a_start} !== 5'b11000) begin
            n_err++; $display("FAIL async_reset: got %b expected 11000",
                              {a_core_ready, a_bus_ready, a_imem_we, a_core_reading, a_start});
        end
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        int br, bi, bs, ifn;
        bit gap;
        logic [1:0]  fence;
        logic [1:0]  model_fence;
        logic [15:0] mask;
        model_fence = 2'd0;
        for (int it = 0; it < 5; it++) begin
            ifn   = int'($urandom_range(0, 3));
            fence = 2'($urandom);
            mask  = 16'($urandom);
            mask[0] = 1'($urandom_range(0, 1));
            gap   = 1'($urandom_range(0, 1));
            make_program(2'(ifn), fence, mask, 16'($urandom), 1'b0);
            exp_r0.delete(); exp_im.delete(); expect_for(0);
            if (exp_sel) model_fence = fence;
            br = obs_r0_a.size(); bi = obs_im_a.size(); bs = start_cnt_a;
            send_program(gap, ifn * 16);
            repeat (4) @(negedge clk);
            #1;
            n_vec++;
            if ((obs_r0_a.size() - br !== exp_r0.size()) || (obs_im_a.size() - bi !== exp_im.size())) begin
                n_err++; $display("FAIL rand%0d_counts: got r0=%0d im=%0d expected r0=%0d im=%0d", it,
                                  obs_r0_a.size() - br, obs_im_a.size() - bi, exp_r0.size(), exp_im.size());
            end else begin
                for (int i = 0; i < exp_r0.size(); i++) begin
                    n_vec++;
                    if (obs_r0_a[br + i] !== exp_r0[i]) begin
                        n_err++; $display("FAIL rand%0d_r0[%0d]: got %h expected %h", it, i, obs_r0_a[br + i], exp_r0[i]);
                    end
                end
                for (int i = 0; i < exp_im.size(); i++) begin
                    n_vec++;
                    if (obs_im_a[bi + i] !== exp_im[i]) begin
                        n_err++; $display("FAIL rand%0d_im[%0d]: got %h expected %h", it, i, obs_im_a[bi + i], exp_im[i]);
                    end
                end
            end
            n_vec++;
            if ({start_cnt_a - bs, a_fence} !== {32'(exp_sel), model_fence}) begin
                n_err++; $display("FAIL rand%0d_start_fence: got start=%0d fence=%0d expected %0d/%0d",
                                  it, start_cnt_a - bs, a_fence, exp_sel, model_fence);
            end
            if (exp_sel) begin
                @(negedge clk) core_done_a = 1'b1;
                @(negedge clk) core_done_a = 1'b0;
            end
            n_vec++;
            if (a_core_ready !== 1'b1) begin
                n_err++; $display("FAIL rand%0d_idle: got core_ready=%b expected 1", it, a_core_ready);
            end
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        bus_data    = '0;
        bus_valid   = 1'b0;
        bus_sof     = 1'b0;
        tgt         = 1'b0;
        core_done_a = 1'b0;
        core_done_b = 1'b0;
        test_reset();
        test_full_load();
        test_not_selected();
        test_core_id_select();
        test_lane_mask();
        test_no_instr();
        test_abort();
        test_valid_toggle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
